increment_compare_engine: RTL and testbench
===========================================

# increment_compare_engine

Time-multiplexed, stateful increment-and-compare engine: it holds per-element beamforming delay (n) and error registers for NUM_ELEMENTS transducer elements. It advances all of them by one scan point per start/ack transaction. NUM_LANES parallel datapaths are shared round-robin over element groups, and each element may take up to MAX_ITER increments per scan point, with saturation and fault reporting. It sits between the next-point increment-term calculator (drives term_in/step_in) and the delay consumer (reads n_out/error_out on valid).

## Interface
- NUM_ELEMENTS, 64, element count; must be a multiple of NUM_LANES
- NUM_LANES, 8, parallel datapaths; G = NUM_ELEMENTS/NUM_LANES groups
- DW_N_INTEGER, 13, delay integer bits
- DW_ERROR_INTEGER, 14, error integer bits
- DW_INC_TERM_INTEGER, 16, increment-term integer bits
- DW_FRACTION, 4, fraction bits; INC = 1<<DW_FRACTION (one integer unit)
- MAX_ITER, 4, compare/increment iterations per element per scan point (>=1)

Ports:
- clk  in  1  clock; all state rises on posedge
- rst  in  1  reset; asynchronous and active-low
- load  in  1  capture n_init/error_init (IDLE only)
- n_init  in  [NUM_ELEMENTS] x (DW_N_INTEGER+DW_FRACTION+1)  unsigned initial delays
- error_init  in  [NUM_ELEMENTS] x (DW_ERROR_INTEGER+DW_FRACTION+1)  signed initial errors
- start  in  1  begin one scan-point update (IDLE only)
- term_in  in  [NUM_ELEMENTS] x (DW_INC_TERM_INTEGER+DW_FRACTION+1)  signed increment terms
- step_in  in  [NUM_ELEMENTS] x (DW_ERROR_INTEGER+DW_FRACTION)  unsigned per-increment error decrement
- ack  in  1  consumer has read results
- n_out  out  [NUM_ELEMENTS] x (DW_N_INTEGER+DW_FRACTION+1)  delay registers
- error_out  out  [NUM_ELEMENTS] x (DW_ERROR_INTEGER+DW_FRACTION+1)  error registers
- fault  out  NUM_ELEMENTS  per-element saturation/unresolved flag
- busy  out  1  high in RUN and DONE
- valid  out  1  high in DONE; results stable

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - load=1 copies n_init/error_init into the registers.
  - Otherwise start=1 captures term_in/step_in into shadow registers, clears fault, zeroes the group counter g and the iteration counter k, and enters RUN.
  - If load and start are both high, load wins and start is ignored.
- RUN, group g covers elements g*NUM_LANES .. g*NUM_LANES+NUM_LANES-1:
  - k=0: e = e + term. The sum is formed one bit wider than the wider operand, then saturated to the error range. If saturation occurs, set fault.
  - k=1..MAX_ITER: per lane, if e >= 0 then n += INC and e -= step. If n+INC would exceed 2^(DW_N_INTEGER+DW_FRACTION+1)-1, n and e hold and fault is set. If e < 0, the lane holds.
  - e - step with e >= 0 cannot overflow. No early exit is taken.
  - After k=MAX_ITER, any element in the group with e >= 0 sets fault (unresolved).
  - g increments; after group G-1 the FSM enters DONE.
- DONE: valid=1. ack=1 returns the FSM to IDLE. start and load are ignored.
- ack outside DONE is ignored. start and load outside IDLE are ignored.
- n_out/error_out always show the registers. They change only during load and RUN.
- step=0 with e >= 0 increments on every iteration and then sets fault.

## Timing
- Reset asserted: FSM=IDLE; n, error, shadow registers, counters and fault are all 0; busy=0, valid=0. Reset is effective immediately, including mid-RUN or mid-DONE; any in-flight update is discarded.
- Load: registers update at the sampling edge and are visible the next cycle.
- Start sampled at edge t:
  - busy=1 from t+1.
  - RUN lasts exactly G*(1+MAX_ITER) cycles (default 40).
  - valid=1 from edge t+G*(1+MAX_ITER).
- Latency is data-independent.
- Ack sampled with valid=1 at edge u: valid=0 and busy=0 from u+1. The next start is accepted at edge u+1 or later.
- Ack held high before valid rises completes the transaction in the first DONE cycle, so valid is high for a single cycle.

## Test plan
- Reset: rst low mid-traffic → all outputs 0, busy=valid=0 immediately. After release, start is accepted normally.
- Nominal: load n=100, e=-8 for all elements; start with term=40, step=16 → valid 40 cycles after the start edge; n=148, e=-16, fault=0.
- Unresolved: e=0, term=1, step=0 → n=init+64, e=1, fault=1.
- Saturation: n=262140, e=0, term=16, step=16 → n=262140, e=16, fault=1. Also error_init=max with term=max → e clamps to max and fault=1.
- Handshake: start pulsed in RUN and load pulsed in DONE are ignored; ack before valid is ignored; ack at valid → idle next cycle; back-to-back transactions give incremental results.
- Parametrisation: random distinct per-element terms with NUM_LANES=8 and with NUM_LANES=1 → identical n/error/fault; latency 40 vs 320 cycles.

Source files
------------

// File: rtl/increment_compare_engine.sv
// Time-multiplexed increment-and-compare engine for per-element beamforming
// delay (n) and error registers. NUM_LANES lane datapaths walk the element
// groups round-robin; each group gets one add cycle plus MAX_ITER
// compare/increment cycles per scan point.

module ice_lane #(
    parameter int NW   = 18,
    parameter int EW   = 19,
    parameter int TW   = 21,
    parameter int SW   = 18,
    parameter int FRAC = 4
) (
    input  logic [NW-1:0]        n,
    input  logic signed [EW-1:0] e,
    input  logic signed [TW-1:0] term,
    input  logic [SW-1:0]        step,
    input  logic                 add_phase,
    input  logic                 last_iter,
    output logic [NW-1:0]        n_nxt,
    output logic signed [EW-1:0] e_nxt,
    output logic                 fault_set
);
    // Sum is one bit wider than the wider operand so it can never wrap.
    localparam int SUMW = ((EW > TW) ? EW : TW) + 1;
    localparam logic signed [SUMW-1:0] EMAX = SUMW'((longint'(1) << (EW - 1)) - 1);
    localparam logic signed [SUMW-1:0] EMIN = SUMW'(-(longint'(1) << (EW - 1)));
    localparam logic [NW:0] INC = (NW + 1)'(1 << FRAC);

    logic signed [SUMW-1:0] sum;
    logic [NW:0]            n_plus;

    // One lane step: saturating add on k=0, conditional increment otherwise.
    always_comb begin
        sum       = SUMW'(e) + SUMW'(term);
        n_plus    = {1'b0, n} + INC;
        n_nxt     = n;
        e_nxt     = e;
        fault_set = 1'b0;
        if (add_phase) begin
            if (sum > EMAX) begin
                e_nxt     = EW'(EMAX);
                fault_set = 1'b1;
            end else if (sum < EMIN) begin
                e_nxt     = EW'(EMIN);
                fault_set = 1'b1;
            end else begin
                e_nxt = EW'(sum);
            end
        end else if (!e[EW-1]) begin
            // n would leave its range: hold both registers and flag it.
            if (n_plus[NW]) begin
                fault_set = 1'b1;
            end else begin
                n_nxt = n_plus[NW-1:0];
                // e >= 0 and step < 2^(EW-1), so this cannot overflow.
                e_nxt = e - $signed({1'b0, step});
            end
        end
        // Still non-negative after the final iteration: delay unresolved.
        if (last_iter && !e_nxt[EW-1])
            fault_set = 1'b1;
    end
endmodule

module increment_compare_engine #(
    parameter int NUM_ELEMENTS        = 64,
    parameter int NUM_LANES           = 8,
    parameter int DW_N_INTEGER        = 13,
    parameter int DW_ERROR_INTEGER    = 14,
    parameter int DW_INC_TERM_INTEGER = 16,
    parameter int DW_FRACTION         = 4,
    parameter int MAX_ITER            = 4
) (
    input  logic                                                              clk,
    input  logic                                                              rst,
    input  logic                                                              load,
    input  logic [NUM_ELEMENTS-1:0][DW_N_INTEGER+DW_FRACTION:0]               n_init,
    input  logic [NUM_ELEMENTS-1:0][DW_ERROR_INTEGER+DW_FRACTION:0]           error_init,
    input  logic                                                              start,
    input  logic [NUM_ELEMENTS-1:0][DW_INC_TERM_INTEGER+DW_FRACTION:0]        term_in,
    input  logic [NUM_ELEMENTS-1:0][DW_ERROR_INTEGER+DW_FRACTION-1:0]         step_in,
    input  logic                                                              ack,
    output logic [NUM_ELEMENTS-1:0][DW_N_INTEGER+DW_FRACTION:0]               n_out,
    output logic [NUM_ELEMENTS-1:0][DW_ERROR_INTEGER+DW_FRACTION:0]           error_out,
    output logic [NUM_ELEMENTS-1:0]                                           fault,
    output logic                                                              busy,
    output logic                                                              valid
);
    localparam int NW = DW_N_INTEGER + DW_FRACTION + 1;
    localparam int EW = DW_ERROR_INTEGER + DW_FRACTION + 1;
    localparam int TW = DW_INC_TERM_INTEGER + DW_FRACTION + 1;
    localparam int SW = DW_ERROR_INTEGER + DW_FRACTION;
    localparam int G  = NUM_ELEMENTS / NUM_LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int KW = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [NUM_ELEMENTS-1:0][NW-1:0] n_r;
    logic [NUM_ELEMENTS-1:0][EW-1:0] e_r;
    logic [NUM_ELEMENTS-1:0][TW-1:0] term_r;
    logic [NUM_ELEMENTS-1:0][SW-1:0] step_r;
    logic [NUM_ELEMENTS-1:0]         fault_r;
    logic [GW-1:0]                   g;
    logic [KW-1:0]                   k;

    logic [NUM_LANES-1:0][NW-1:0] lane_n, lane_n_nxt;
    logic [NUM_LANES-1:0][EW-1:0] lane_e, lane_e_nxt;
    logic [NUM_LANES-1:0][TW-1:0] lane_term;
    logic [NUM_LANES-1:0][SW-1:0] lane_step;
    logic [NUM_LANES-1:0]         lane_fault;

    logic add_phase, last_iter, last_grp;

    assign add_phase = (k == '0);
    assign last_iter = (k == KW'(MAX_ITER));
    assign last_grp  = (g == GW'(G - 1));

    assign n_out     = n_r;
    assign error_out = e_r;
    assign fault     = fault_r;

    // Route the active group's registers onto the shared lanes.
    always_comb begin
        lane_n    = '0;
        lane_e    = '0;
        lane_term = '0;
        lane_step = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            if (GW'(i / NUM_LANES) == g) begin
                lane_n[i % NUM_LANES]    = n_r[i];
                lane_e[i % NUM_LANES]    = e_r[i];
                lane_term[i % NUM_LANES] = term_r[i];
                lane_step[i % NUM_LANES] = step_r[i];
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ice_lane #(.NW(NW), .EW(EW), .TW(TW), .SW(SW), .FRAC(DW_FRACTION)) u_lane (
            .n         (lane_n[l]),
            .e         (lane_e[l]),
            .term      (lane_term[l]),
            .step      (lane_step[l]),
            .add_phase (add_phase),
            .last_iter (last_iter),
            .n_nxt     (lane_n_nxt[l]),
            .e_nxt     (lane_e_nxt[l]),
            .fault_set (lane_fault[l])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and handshake outputs; load has priority over start.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        valid     = (state == DONE);
        case (state)
            IDLE: if (!load && start)         state_nxt = RUN;
            RUN:  if (last_iter && last_grp)  state_nxt = DONE;
            DONE: if (ack)                    state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Register file, shadow operands, fault flags and group/iteration counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_r     <= '0;
            e_r     <= '0;
            term_r  <= '0;
            step_r  <= '0;
            fault_r <= '0;
            g       <= '0;
            k       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        n_r <= n_init;
                        e_r <= error_init;
                    end else if (start) begin
                        term_r  <= term_in;
                        step_r  <= step_in;
                        fault_r <= '0;
                        g       <= '0;
                        k       <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_ELEMENTS; i++) begin
                        if (GW'(i / NUM_LANES) == g) begin
                            n_r[i]     <= lane_n_nxt[i % NUM_LANES];
                            e_r[i]     <= lane_e_nxt[i % NUM_LANES];
                            fault_r[i] <= fault_r[i] | lane_fault[i % NUM_LANES];
                        end
                    end
                    if (last_iter) begin
                        k <= '0;
                        g <= g + 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_increment_compare_engine.sv
// Bench for increment_compare_engine: randomized scan points against a
// per-element arithmetic model, plus directed handshake/reset/saturation cases.

module tb_increment_compare_engine;
    localparam int NE = 64;
    localparam int MI = 4;
    localparam int NW = 18;
    localparam int EW = 19;
    localparam int TW = 21;
    localparam int SW = 18;
    localparam longint NMAX = (longint'(1) << NW) - 1;
    localparam longint EMAX = (longint'(1) << (EW - 1)) - 1;
    localparam longint EMIN = -(longint'(1) << (EW - 1));
    localparam longint TMAX = (longint'(1) << (TW - 1)) - 1;
    localparam longint TMIN = -(longint'(1) << (TW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NE-1:0][NW-1:0] n_init;
    logic [NE-1:0][EW-1:0] error_init;
    logic [NE-1:0][TW-1:0] term_in;
    logic [NE-1:0][SW-1:0] step_in;
    logic load8 = 0, start8 = 0, ack8 = 0;
    logic load1 = 0, start1 = 0, ack1 = 0;
    logic [NE-1:0][NW-1:0] n8, n1;
    logic [NE-1:0][EW-1:0] e8, e1;
    logic [NE-1:0]         f8, f1;
    logic busy8, valid8, busy1, valid1;

    logic [NE-1:0][NW-1:0] exp_n;
    logic [NE-1:0][EW-1:0] exp_e;
    logic [NE-1:0]         exp_f;

    longint mn[NE], me[NE], tm[NE], st[NE], in_n[NE], in_e[NE];
    bit     mf[NE];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    increment_compare_engine #(.NUM_LANES(8)) dut8 (
        .clk(clk), .rst(rst), .load(load8), .n_init(n_init), .error_init(error_init),
        .start(start8), .term_in(term_in), .step_in(step_in), .ack(ack8),
        .n_out(n8), .error_out(e8), .fault(f8), .busy(busy8), .valid(valid8));

    increment_compare_engine #(.NUM_LANES(1)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .n_init(n_init), .error_init(error_init),
        .start(start1), .term_in(term_in), .step_in(step_in), .ack(ack1),
        .n_out(n1), .error_out(e1), .fault(f1), .busy(busy1), .valid(valid1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: one scan point applied to every element independently.
    function automatic void model_apply();
        for (int i = 0; i < NE; i++) begin
            longint s;
            s = me[i] + tm[i];
            mf[i] = 0;
            if (s > EMAX) begin s = EMAX; mf[i] = 1; end
            else if (s < EMIN) begin s = EMIN; mf[i] = 1; end
            me[i] = s;
            for (int it = 0; it < MI; it++) begin
                if (me[i] >= 0) begin
                    if (mn[i] + 16 > NMAX) mf[i] = 1;
                    else begin mn[i] += 16; me[i] -= st[i]; end
                end
            end
            if (me[i] >= 0) mf[i] = 1;
        end
    endfunction

    function automatic void pack_expect();
        for (int i = 0; i < NE; i++) begin
            exp_n[i] = NW'(mn[i]);
            exp_e[i] = EW'(me[i]);
            exp_f[i] = mf[i];
        end
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < NE; i++) begin
            n_init[i]     = NW'(in_n[i]);
            error_init[i] = EW'(in_e[i]);
            term_in[i]    = TW'(tm[i]);
            step_in[i]    = SW'(st[i]);
        end
    endtask

    task automatic load_both();
        drive_bus();
        load8 = 1; load1 = 1;
        tick();
        load8 = 0; load1 = 0;
        for (int i = 0; i < NE; i++) begin mn[i] = in_n[i]; me[i] = in_e[i]; end
    endtask

    task automatic start_wait8(output int lat, output logic busy_at_start);
        start8 = 1;
        tick();
        start8 = 0;
        busy_at_start = busy8;
        lat = 0;
        while (!valid8 && lat < 500) begin tick(); lat++; end
    endtask

    task automatic ack_8();
        ack8 = 1;
        tick();
        ack8 = 0;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NE; i++) begin
            in_n[i] = longint'($urandom_range(0, 131072));
            in_e[i] = longint'($urandom_range(0, 1024)) - 512;
            tm[i]   = longint'($urandom_range(0, 600)) - 300 + i;
            st[i]   = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(1, 200));
        end
    endtask

    task automatic test_reset();
        rst = 0;
        #1;
        tick();
        n_cmp++;
        if (n8 !== '0 || e8 !== '0 || f8 !== '0) begin
            n_bad++; $display("FAIL reset_regs: got n|e|f nonzero, want all 0");
        end
        n_cmp++;
        if ({busy8, valid8} !== 2'b00) begin
            n_bad++; $display("FAIL reset_hs: got busy/valid %b want 00", {busy8, valid8});
        end
        rst = 1;
        tick();
        n_cmp++;
        if ({busy8, valid8, busy1, valid1} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_release: got %b want 0000", {busy8, valid8, busy1, valid1});
        end
    endtask

    task automatic check8_results(input string tag);
        pack_expect();
        for (int i = 0; i < NE; i++) begin
            n_cmp++;
            if ({n8[i], e8[i], f8[i]} !== {exp_n[i], exp_e[i], exp_f[i]}) begin
                n_bad++;
                $display("FAIL %s elem %0d: got n=%0d e=%h f=%b want n=%0d e=%h f=%b",
                         tag, i, n8[i], e8[i], f8[i], exp_n[i], exp_e[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_nominal();
        int lat; logic b;
        for (int i = 0; i < NE; i++) begin in_n[i] = 100; in_e[i] = -8; tm[i] = 40; st[i] = 16; end
        load_both();
        start_wait8(lat, b);
        model_apply();
        n_cmp++;
        if (lat !== 40) begin n_bad++; $display("FAIL nominal_latency: got %0d want 40", lat); end
        n_cmp++;
        if (b !== 1'b1) begin n_bad++; $display("FAIL nominal_busy: got %b want 1", b); end
        n_cmp++;
        if (n8[5] !== 18'd148 || e8[5] !== 19'h7fff0 || f8[5] !== 1'b0) begin
            n_bad++; $display("FAIL nominal_fixed: got n=%0d e=%h f=%b want 148 7fff0 0", n8[5], e8[5], f8[5]);
        end
        check8_results("nominal");
        ack_8();
        n_cmp++;
        if ({busy8, valid8} !== 2'b00) begin
            n_bad++; $display("FAIL nominal_ack: got busy/valid %b want 00", {busy8, valid8});
        end
    endtask

    task automatic test_unresolved();
        int lat; logic b;
        for (int i = 0; i < NE; i++) begin
            in_n[i] = longint'($urandom_range(0, 1000)); in_e[i] = 0; tm[i] = 1; st[i] = 0;
        end
        load_both();
        start_wait8(lat, b);
        model_apply();
        n_cmp++;
        if (n8[0] !== NW'(in_n[0] + 64) || e8[0] !== 19'd1 || f8[0] !== 1'b1) begin
            n_bad++; $display("FAIL unresolved_fixed: got n=%0d e=%h f=%b want n=%0d e=1 f=1",
                              n8[0], e8[0], f8[0], in_n[0] + 64);
        end
        check8_results("unresolved");
        ack_8();
    endtask

    task automatic test_saturation();
        int lat; logic b;
        for (int i = 0; i < NE; i++) begin in_n[i] = 262140; in_e[i] = 0; tm[i] = 16; st[i] = 16; end
        load_both();
        start_wait8(lat, b);
        model_apply();
        n_cmp++;
        if (n8[3] !== 18'd262140 || e8[3] !== 19'd16 || f8[3] !== 1'b1) begin
            n_bad++; $display("FAIL sat_n_fixed: got n=%0d e=%h f=%b want 262140 10 1", n8[3], e8[3], f8[3]);
        end
        check8_results("sat_n");
        ack_8();
        // Even elements clamp high, odd elements clamp low.
        for (int i = 0; i < NE; i++) begin
            in_n[i] = 262140;
            in_e[i] = (i % 2 == 0) ? EMAX : EMIN;
            tm[i]   = (i % 2 == 0) ? TMAX : TMIN;
            st[i]   = longint'($urandom_range(0, 1000));
        end
        load_both();
        start_wait8(lat, b);
        model_apply();
        n_cmp++;
        if (e8[0] !== 19'h3ffff || e8[1] !== 19'h40000 || f8[1:0] !== 2'b11) begin
            n_bad++; $display("FAIL sat_e_fixed: got e0=%h e1=%h f=%b want 3ffff 40000 11", e8[0], e8[1], f8[1:0]);
        end
        check8_results("sat_e");
        ack_8();
    endtask

    task automatic test_handshake();
        int lat;
        randomize_data();
        load_both();
        start8 = 1;
        tick();
        start8 = 0;
        lat = 0;
        repeat (3) begin tick(); lat++; end
        // Junk on the bus plus load/start/ack mid-RUN must all be ignored.
        for (int i = 0; i < NE; i++) n_init[i] = NW'(i * 7);
        load8 = 1; start8 = 1; ack8 = 1;
        tick(); lat++;
        load8 = 0; start8 = 0; ack8 = 0;
        while (!valid8 && lat < 500) begin tick(); lat++; end
        model_apply();
        n_cmp++;
        if (lat !== 40) begin n_bad++; $display("FAIL hs_latency: got %0d want 40", lat); end
        check8_results("hs_run");
        load8 = 1; start8 = 1;
        tick();
        load8 = 0; start8 = 0;
        n_cmp++;
        if ({busy8, valid8} !== 2'b11) begin
            n_bad++; $display("FAIL hs_done_hold: got busy/valid %b want 11", {busy8, valid8});
        end
        check8_results("hs_done");
        ack_8();
        n_cmp++;
        if ({busy8, valid8} !== 2'b00) begin
            n_bad++; $display("FAIL hs_ack: got busy/valid %b want 00", {busy8, valid8});
        end
    endtask

    task automatic test_ack_early();
        int vcnt;
        randomize_data();
        load_both();
        start8 = 1;
        tick();
        start8 = 0;
        ack8 = 1;
        vcnt = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (valid8) vcnt++;
        end
        ack8 = 0;
        model_apply();
        n_cmp++;
        if (vcnt !== 1) begin n_bad++; $display("FAIL ack_early_valid_cycles: got %0d want 1", vcnt); end
        n_cmp++;
        if (busy8 !== 1'b0) begin n_bad++; $display("FAIL ack_early_idle: got busy %b want 0", busy8); end
        check8_results("ack_early");
    endtask

    task automatic test_back_to_back();
        int lat; logic b;
        randomize_data();
        load_both();
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < NE; i++) begin
                tm[i] = longint'($urandom_range(0, 400)) - 150;
                st[i] = longint'($urandom_range(1, 100));
            end
            drive_bus();
            start_wait8(lat, b);
            model_apply();
            n_cmp++;
            if (lat !== 40 || b !== 1'b1) begin
                n_bad++; $display("FAIL b2b_timing txn %0d: got lat=%0d busy=%b want 40 1", t, lat, b);
            end
            check8_results("b2b");
            ack_8();
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic b;
        randomize_data();
        load_both();
        start8 = 1;
        tick();
        start8 = 0;
        repeat (10) tick();
        #2 rst = 0;
        #1;
        n_cmp++;
        if (n8 !== '0 || e8 !== '0 || f8 !== '0 || {busy8, valid8} !== 2'b00) begin
            n_bad++; $display("FAIL reset_mid: got busy/valid %b or nonzero regs, want all 0", {busy8, valid8});
        end
        tick();
        rst = 1;
        tick();
        for (int i = 0; i < NE; i++) begin mn[i] = 0; me[i] = 0; end
        randomize_data();
        load_both();
        start_wait8(lat, b);
        model_apply();
        n_cmp++;
        if (lat !== 40) begin n_bad++; $display("FAIL reset_mid_latency: got %0d want 40", lat); end
        check8_results("reset_mid");
        ack_8();
    endtask

    task automatic test_param();
        int lat8, lat1, c;
        randomize_data();
        load_both();
        start8 = 1; start1 = 1;
        tick();
        start8 = 0; start1 = 0;
        lat8 = -1; lat1 = -1; c = 0;
        while (lat1 < 0 && c < 500) begin
            tick(); c++;
            if (valid8 && lat8 < 0) lat8 = c;
            if (valid1 && lat1 < 0) lat1 = c;
        end
        model_apply();
        pack_expect();
        n_cmp++;
        if (lat8 !== 40 || lat1 !== 320) begin
            n_bad++; $display("FAIL param_latency: got %0d/%0d want 40/320", lat8, lat1);
        end
        check8_results("param_l8");
        for (int i = 0; i < NE; i++) begin
            n_cmp++;
            if ({n1[i], e1[i], f1[i]} !== {exp_n[i], exp_e[i], exp_f[i]}) begin
                n_bad++;
                $display("FAIL param_l1 elem %0d: got n=%0d e=%h f=%b want n=%0d e=%h f=%b",
                         i, n1[i], e1[i], f1[i], exp_n[i], exp_e[i], exp_f[i]);
            end
        end
        ack8 = 1; ack1 = 1;
        tick();
        ack8 = 0; ack1 = 0;
    endtask

    initial begin
        n_init = '0; error_init = '0; term_in = '0; step_in = '0;
        test_reset();
        test_nominal();
        test_unresolved();
        test_saturation();
        test_handshake();
        test_ack_early();
        test_back_to_back();
        test_reset_mid();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
